// File: rtl/complex_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// complex_accumulator_pkg
//
// Purpose : Shared width helpers for the complex accumulator slice.
//           - axis_width(): AXI-Stream bus width for an I/Q pair, rounded up
//                           to a multiple of 16 bits.
//           - acc_width() : per-component accumulator width, sized so a full
//                           frame of extreme inputs can never overflow.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package complex_accumulator_pkg;

    function automatic int axis_width(input int component_width);
        return ((2 * component_width + 15) / 16) * 16;
    endfunction

    function automatic int acc_width(input int operand_width, input int max_len_log2);
        return operand_width + max_len_log2 + 1;
    endfunction

endpackage

// File: rtl/complex_acc_lane.sv
// -----------------------------------------------------------------------------
// complex_acc_lane
//
// Purpose : One component (I or Q) of the complex accumulator. Loads the
//           accumulator on the first beat of a frame, adds on the following
//           beats, and on the last beat shifts the final sum, narrows it to
//           OPERAND_WIDTH_OUT and registers it as the lane output.
//           Narrowing mode is selected by the COMPLEX_ACCUMULATOR_SAT_EN macro:
//             defined   -> clamp to signed min/max, dout_sat flags a clamp
//             undefined -> keep the low OPERAND_WIDTH_OUT bits, dout_sat = 0
// Ports   :
//   aclk      in   clock, rising edge
//   aresetn   in   synchronous active-low reset
//   din       in   signed input component
//   beat      in   a beat is accepted this cycle
//   first     in   accepted beat is the first of its frame
//   last      in   accepted beat is the last of its frame (dump)
//   dout      out  registered narrowed frame sum
//   dout_sat  out  registered clamp flag for dout
// -----------------------------------------------------------------------------
module complex_acc_lane
    import complex_accumulator_pkg::*;
#(
    parameter int OPERAND_WIDTH_IN  = 32,
    parameter int OPERAND_WIDTH_OUT = 32,
    parameter int MAX_LEN_LOG2      = 10,
    parameter int SHIFT             = 0
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic signed [OPERAND_WIDTH_IN-1:0]  din,
    input  logic                                beat,
    input  logic                                first,
    input  logic                                last,
    output logic signed [OPERAND_WIDTH_OUT-1:0] dout,
    output logic                                dout_sat
);

    localparam int ACC_W = acc_width(OPERAND_WIDTH_IN, MAX_LEN_LOG2);
    localparam int OW    = OPERAND_WIDTH_OUT;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] din_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [OW-1:0]    narrow;
    logic                    narrow_sat;

    assign din_ext = ACC_W'(din);
    // The first beat overwrites whatever is left in acc_q, so a stale partial
    // sum can never leak into a new frame.
    assign sum     = first ? din_ext : acc_q + din_ext;

`ifdef COMPLEX_ACCUMULATOR_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    assign shifted = sum >>> SHIFT;

    if (OW >= ACC_W) begin : g_no_clamp
        assign narrow     = OW'(shifted);
        assign narrow_sat = 1'b0;
    end else begin : g_clamp
        // In range iff every bit from the output sign bit upward agrees.
        logic [ACC_W-OW:0] top_bits;
        assign top_bits = shifted[ACC_W-1:OW-1];

        // NOTE: both outputs get a default first so no path leaves them
        // unassigned, which would otherwise infer a latch.
        always_comb begin
            narrow     = shifted[OW-1:0];
            narrow_sat = 1'b0;
            if (!((&top_bits) || (~|top_bits))) begin
                narrow_sat = 1'b1;
                narrow     = shifted[ACC_W-1] ? {1'b1, {(OW-1){1'b0}}}
                                              : {1'b0, {(OW-1){1'b1}}};
            end
        end
    end
`else
    // Wrap: the cast keeps the low OW bits (or sign-extends if OW is wider).
    assign narrow     = OW'(sum >>> SHIFT);
    assign narrow_sat = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_q    <= '0;
            dout     <= '0;
            dout_sat <= 1'b0;
        end else if (beat) begin
            acc_q <= last ? '0 : sum;
            if (last) begin
                dout     <= narrow;
                dout_sat <= narrow_sat;
            end
        end
    end

endmodule

// File: rtl/complex_accumulator.sv
// -----------------------------------------------------------------------------
// complex_accumulator
//
// Purpose : Accumulates cfg_len complex samples per frame and emits the sum on
//           an AXI-Stream master through a one-entry output register. cfg_len
//           is latched on the first beat of each frame (0 -> 1, values above
//           2^MAX_LEN_LOG2 clamped). Optional saturation of the narrowed output
//           is enabled by defining COMPLEX_ACCUMULATOR_SAT_EN; without it the
//           output wraps and m_axis_dout_tuser stays 0.
// Ports   :
//   aclk                in   clock, rising edge
//   aresetn             in   synchronous active-low reset
//   cfg_len             in   samples per dump, MAX_LEN_LOG2+1 bits
//   s_axis_tdata        in   {pad, imag, pad, real}, each half of the bus
//   s_axis_tvalid       in   slave valid
//   s_axis_tready       out  slave ready (combinational)
//   m_axis_dout_tdata   out  {imag, real}, same packing as the input
//   m_axis_dout_tvalid  out  master valid
//   m_axis_dout_tready  in   master ready
//   m_axis_dout_tuser   out  1 when either component was clamped
// -----------------------------------------------------------------------------
module complex_accumulator
    import complex_accumulator_pkg::*;
#(
    parameter int OPERAND_WIDTH_IN  = 32,
    parameter int OPERAND_WIDTH_OUT = 32,
    parameter int MAX_LEN_LOG2      = 10,
    parameter int SHIFT             = 0
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic [MAX_LEN_LOG2:0]                      cfg_len,
    input  logic [axis_width(OPERAND_WIDTH_IN)-1:0]    s_axis_tdata,
    input  logic                                       s_axis_tvalid,
    output logic                                       s_axis_tready,
    output logic [axis_width(OPERAND_WIDTH_OUT)-1:0]   m_axis_dout_tdata,
    output logic                                       m_axis_dout_tvalid,
    input  logic                                       m_axis_dout_tready,
    output logic                                       m_axis_dout_tuser
);

    localparam int IN_HALF  = axis_width(OPERAND_WIDTH_IN) / 2;
    localparam int OUT_HALF = axis_width(OPERAND_WIDTH_OUT) / 2;
    localparam int CNT_W    = MAX_LEN_LOG2 + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {MAX_LEN_LOG2{1'b0}}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] frame_len;
    logic             beat;
    logic             first;
    logic             last;
    logic             dout_valid_q;

    logic signed [OPERAND_WIDTH_IN-1:0]  re_in;
    logic signed [OPERAND_WIDTH_IN-1:0]  im_in;
    logic signed [OPERAND_WIDTH_OUT-1:0] re_out;
    logic signed [OPERAND_WIDTH_OUT-1:0] im_out;
    logic                                re_sat;
    logic                                im_sat;

    assign re_in = s_axis_tdata[OPERAND_WIDTH_IN-1:0];
    assign im_in = s_axis_tdata[IN_HALF +: OPERAND_WIDTH_IN];

    // Accept whenever the output register is empty or being drained this edge.
    assign s_axis_tready = !dout_valid_q || m_axis_dout_tready;
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign first         = (count_q == '0);

    always_comb begin
        len_eff = cfg_len;
        if (cfg_len == '0) begin
            len_eff = CNT_W'(1);
        end else if (cfg_len > MAX_LEN) begin
            len_eff = MAX_LEN;
        end
    end

    // Mid-frame cfg_len changes are invisible: only the first beat uses it.
    assign frame_len = first ? len_eff : len_q;
    assign last      = (count_q == frame_len - CNT_W'(1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count_q      <= '0;
            len_q        <= CNT_W'(1);
            dout_valid_q <= 1'b0;
        end else begin
            if (beat) begin
                count_q <= last ? '0 : count_q + CNT_W'(1);
                if (first) begin
                    len_q <= len_eff;
                end
            end
            // A dump landing on the same edge as a transfer keeps valid high.
            if (beat && last) begin
                dout_valid_q <= 1'b1;
            end else if (m_axis_dout_tready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    complex_acc_lane #(
        .OPERAND_WIDTH_IN (OPERAND_WIDTH_IN),
        .OPERAND_WIDTH_OUT(OPERAND_WIDTH_OUT),
        .MAX_LEN_LOG2     (MAX_LEN_LOG2),
        .SHIFT            (SHIFT)
    ) u_lane_i (
        .aclk    (aclk),
        .aresetn (aresetn),
        .din     (re_in),
        .beat    (beat),
        .first   (first),
        .last    (last),
        .dout    (re_out),
        .dout_sat(re_sat)
    );

    complex_acc_lane #(
        .OPERAND_WIDTH_IN (OPERAND_WIDTH_IN),
        .OPERAND_WIDTH_OUT(OPERAND_WIDTH_OUT),
        .MAX_LEN_LOG2     (MAX_LEN_LOG2),
        .SHIFT            (SHIFT)
    ) u_lane_q (
        .aclk    (aclk),
        .aresetn (aresetn),
        .din     (im_in),
        .beat    (beat),
        .first   (first),
        .last    (last),
        .dout    (im_out),
        .dout_sat(im_sat)
    );

    // Signed casts sign-extend each component into its half of the bus.
    assign m_axis_dout_tdata  = {OUT_HALF'(im_out), OUT_HALF'(re_out)};
    assign m_axis_dout_tvalid = dout_valid_q;
    assign m_axis_dout_tuser  = re_sat || im_sat;

endmodule

// File: tb/tb_complex_accumulator.sv
// -----------------------------------------------------------------------------
// tb_complex_accumulator
//
// Self-checking bench for complex_accumulator with 16-bit components and a
// 16-sample maximum frame. Table-driven single-beat frames, hand-written
// multi-cycle sequences, then randomized traffic against a frame-level model.
// Expectations follow COMPLEX_ACCUMULATOR_SAT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_complex_accumulator;

    localparam int IW   = 16;
    localparam int OW   = 16;
    localparam int LL   = 4;
    localparam int SH   = 0;
    localparam int MAXL = 16;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [LL:0] cfg_len = '0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_dout_tdata;
    logic        m_axis_dout_tvalid;
    logic        m_axis_dout_tready = 1'b1;
    logic        m_axis_dout_tuser;

    logic signed [15:0] dut_re;
    logic signed [15:0] dut_im;
    assign dut_re = m_axis_dout_tdata[15:0];
    assign dut_im = m_axis_dout_tdata[31:16];

    always #5 aclk = ~aclk;

    complex_accumulator #(
        .OPERAND_WIDTH_IN (IW),
        .OPERAND_WIDTH_OUT(OW),
        .MAX_LEN_LOG2     (LL),
        .SHIFT            (SH)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .cfg_len           (cfg_len),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .m_axis_dout_tdata (m_axis_dout_tdata),
        .m_axis_dout_tvalid(m_axis_dout_tvalid),
        .m_axis_dout_tready(m_axis_dout_tready),
        .m_axis_dout_tuser (m_axis_dout_tuser)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input int re, input int im, input bit valid);
        s_axis_tdata  = {16'(im), 16'(re)};
        s_axis_tvalid = valid;
    endtask

    task automatic expect_out(input string name, input int re, input int im, input bit user);
        check({name, ".tvalid"}, m_axis_dout_tvalid, 1);
        check({name, ".re"}, dut_re, re);
        check({name, ".im"}, dut_im, im);
        check({name, ".tuser"}, m_axis_dout_tuser, user);
    endtask

    task automatic do_reset();
        drive(0, 0, 1'b0);
        aresetn = 1'b0;
        tick();
        tick();
        check("reset.tvalid", m_axis_dout_tvalid, 0);
        check("reset.tdata", m_axis_dout_tdata, 0);
        check("reset.tuser", m_axis_dout_tuser, 0);
        check("reset.s_tready", s_axis_tready, 1);
        aresetn = 1'b1;
    endtask

    // Frame-level reference: scale, then clamp or wrap to 16 signed bits.
    function automatic longint narrow16(input longint v, output bit clamped);
        longint s;
        s = v >>> SH;
        clamped = 1'b0;
`ifdef COMPLEX_ACCUMULATOR_SAT_EN
        if (s > 32767) begin
            s = 32767;
            clamped = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            clamped = 1'b1;
        end
`else
        s = s & 64'hFFFF;
        if (s >= 32768) s -= 65536;
`endif
        return s;
    endfunction

    function automatic int pick_sample();
        case ($urandom_range(0, 3))
            0: return 32767;
            1: return -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    typedef struct {
        int re;
        int im;
        int exp_re;
        int exp_im;
    } vec_t;

    vec_t tbl[5];

    // Model state for the randomized phase
    int     m_count;
    int     m_len;
    longint m_sre, m_sim;
    bit     m_ov;
    longint m_ore, m_oim;
    bit     m_ouser;

    initial begin
        int exp_re, exp_im;
        bit exp_user;

        tbl[0] = '{5, 7, 5, 7};
        tbl[1] = '{-3, 2, -3, 2};
        tbl[2] = '{32767, -32768, 32767, -32768};
        tbl[3] = '{-1, 0, -1, 0};
        tbl[4] = '{0, 1, 0, 1};

        cfg_len = 5'd4;
        m_axis_dout_tready = 1'b1;
        do_reset();

        // Four (1,-1) beats with cfg_len=4 -> one (4,-4) dump
        cfg_len = 5'd4;
        for (int i = 0; i < 4; i++) begin
            drive(1, -1, 1'b1);
            tick();
            if (i == 2) check("len4.no_early", m_axis_dout_tvalid, 0);
        end
        expect_out("len4", 4, -4, 1'b0);
        drive(0, 0, 1'b0);
        tick();
        check("len4.drained", m_axis_dout_tvalid, 0);

        // Table: cfg_len=1 frames back to back, each output replaces the last
        cfg_len = 5'd1;
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].re, tbl[i].im, 1'b1);
            tick();
            expect_out($sformatf("tbl%0d", i), tbl[i].exp_re, tbl[i].exp_im, 1'b0);
        end
        drive(0, 0, 1'b0);
        tick();
        check("tbl.drained", m_axis_dout_tvalid, 0);

        // cfg_len=0 acts as 1
        cfg_len = 5'd0;
        drive(7, -7, 1'b1);
        tick();
        expect_out("len0", 7, -7, 1'b0);
        drive(0, 0, 1'b0);
        tick();

        // Backpressure: output held, input stalled until downstream ready
        cfg_len = 5'd2;
        m_axis_dout_tready = 1'b0;
        drive(10, 20, 1'b1);
        tick();
        drive(5, -6, 1'b1);
        tick();
        expect_out("bp.dump", 15, 14, 1'b0);
        drive(100, 100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("bp.s_tready_low", s_axis_tready, 0);
            tick();
            expect_out("bp.hold", 15, 14, 1'b0);
        end
        m_axis_dout_tready = 1'b1;
        #1;
        check("bp.s_tready_high", s_axis_tready, 1);
        tick();
        check("bp.transferred", m_axis_dout_tvalid, 0);
        drive(1, 1, 1'b1);
        tick();
        expect_out("bp.second", 101, 101, 1'b0);
        drive(0, 0, 1'b0);
        tick();

        // Narrowing of an out-of-range sum
        cfg_len = 5'd2;
        drive(32767, -32768, 1'b1);
        tick();
        tick();
`ifdef COMPLEX_ACCUMULATOR_SAT_EN
        exp_re = 32767;  exp_im = -32768; exp_user = 1'b1;
`else
        exp_re = -2;     exp_im = 0;      exp_user = 1'b0;
`endif
        expect_out("narrow", exp_re, exp_im, exp_user);
        drive(0, 0, 1'b0);
        tick();

        // Reset mid-frame discards the partial sum
        cfg_len = 5'd4;
        drive(9, 9, 1'b1);
        tick();
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1'b1);
            tick();
            if (i == 2) check("rst.no_early", m_axis_dout_tvalid, 0);
        end
        expect_out("rst.frame", 4, 4, 1'b0);
        drive(0, 0, 1'b0);
        tick();

        // cfg_len change mid-frame applies only to the next frame
        cfg_len = 5'd4;
        drive(1, 2, 1'b1);
        tick();
        cfg_len = 5'd2;
        tick();
        check("cfgchg.no_early", m_axis_dout_tvalid, 0);
        tick();
        tick();
        expect_out("cfgchg.frame1", 4, 8, 1'b0);
        drive(3, 3, 1'b1);
        tick();
        check("cfgchg.gap", m_axis_dout_tvalid, 0);
        tick();
        expect_out("cfgchg.frame2", 6, 6, 1'b0);
        drive(0, 0, 1'b0);
        tick();

        // cfg_len above the maximum clamps to 16
        cfg_len = 5'd31;
        for (int i = 0; i < MAXL; i++) begin
            drive(1, 1, 1'b1);
            tick();
            if (i == MAXL - 2) check("clamp.no_early", m_axis_dout_tvalid, 0);
        end
        expect_out("clamp", 16, 16, 1'b0);
        drive(0, 0, 1'b0);
        tick();

        // Randomized traffic against the frame-level model
        do_reset();
        m_count = 0;
        m_len = 1;
        m_ov = 1'b0;
        m_sre = 0;
        m_sim = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int  re, im;
            bit  v, mr, rdy, acc, c_re, c_im;
            v  = ($urandom_range(0, 9) < 7);
            mr = ($urandom_range(0, 9) < 6);
            re = pick_sample();
            im = pick_sample();
            cfg_len = 5'($urandom_range(0, 31));
            m_axis_dout_tready = mr;
            drive(re, im, v);
            #1;
            rdy = !m_ov || mr;
            check("rand.s_tready", s_axis_tready, rdy);
            acc = v && rdy;
            @(posedge aclk);
            if (m_ov && mr) m_ov = 1'b0;
            if (acc) begin
                if (m_count == 0) begin
                    m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAXL) ? MAXL : int'(cfg_len));
                    m_sre = re;
                    m_sim = im;
                end else begin
                    m_sre += re;
                    m_sim += im;
                end
                m_count++;
                if (m_count == m_len) begin
                    m_ore   = narrow16(m_sre, c_re);
                    m_oim   = narrow16(m_sim, c_im);
                    m_ouser = c_re || c_im;
                    m_ov    = 1'b1;
                    m_count = 0;
                end
            end
            #1;
            check("rand.tvalid", m_axis_dout_tvalid, m_ov);
            if (m_ov) begin
                check("rand.re", dut_re, m_ore);
                check("rand.im", dut_im, m_oim);
                check("rand.tuser", m_axis_dout_tuser, m_ouser);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
